prog_icache: RTL and testbench

//  Parametrised instruction memory with a registered read port for the fetch stage.

---
 rtl/prog_icache.sv | 151 +++++++++++++++
 tb/tb_prog_icache.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prog_icache.sv
// Instruction memory with a registered fetch read port and a byte-stream
// program loader. The loader packs little-endian bytes into words and writes
// them to consecutive addresses. Reads are blocked while a load is running.
module prog_icache #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              not_enable,
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int BPW    = DATA_W / 8;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BPW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, rem_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [DATA_W-1:0]   word_buf, full_word;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic accept, word_wr, len_zero, range_bad;

  assign accept    = (state_q == LOAD) && in_valid;
  assign word_wr   = rst_n && accept && (bcnt_q == BCNT_LAST);
  assign len_zero  = (load_len == '0);
  // One extra bit so base+len cannot wrap back into range.
  assign range_bad = ({1'b0, load_base} + {1'b0, load_len}) > DEPTH_X;

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    full_word = word_buf;
    full_word[8*bcnt_q +: 8] = in_byte;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_zero)        state_d = DONE;
          else if (!range_bad) state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        load_busy = 1'b1;
        if (word_wr && rem_q == ADDR_W'(1)) state_d = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader datapath: word pointer, remaining count, byte lane, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rem_q    <= '0;
      bcnt_q   <= '0;
      word_buf <= '0;
      load_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start && !len_zero) begin
            if (range_bad) begin
              load_err <= 1'b1;
            end else begin
              ptr_q    <= load_base;
              rem_q    <= load_len;
              bcnt_q   <= '0;
              load_err <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            word_buf <= full_word;
            if (bcnt_q == BCNT_LAST) begin
              ptr_q  <= ptr_q + 1'b1;
              rem_q  <= rem_q - 1'b1;
              bcnt_q <= '0;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive rst_n and it maps onto RAM.
    if (word_wr) mem[ptr_q[MEM_AW-1:0]] <= full_word;
  end

  // Registered read port; blocked outside IDLE and when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != IDLE || not_enable) begin
      data  <= '0;
      valid <= 1'b0;
      fault <= 1'b0;
    end else if ({1'b0, index} < DEPTH_X) begin
      data  <= mem[index[MEM_AW-1:0]];
      valid <= 1'b1;
      fault <= 1'b0;
    end else begin
      data  <= '0;
      valid <= 1'b0;
      fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_icache.sv
// Directed self-checking bench for prog_icache (DATA_W=16, DEPTH=1024).
module tb_prog_icache;

  logic        clk = 1'b0;
  logic        rst_n, not_enable, load_start, in_valid;
  logic [31:0] index, load_base, load_len;
  logic [7:0]  in_byte;
  logic [15:0] data;
  logic        valid, fault, in_ready, load_busy, load_done, load_err;

  int errors = 0;
  int checks = 0;

  prog_icache dut (
    .clk(clk), .rst_n(rst_n), .not_enable(not_enable), .index(index),
    .data(data), .valid(valid), .fault(fault), .load_start(load_start),
    .load_base(load_base), .load_len(load_len), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [31:0] len);
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic read(input logic [31:0] idx);
    index = idx;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; not_enable = 1'b0; load_start = 1'b0; in_valid = 1'b0;
    index = '0; load_base = '0; load_len = '0; in_byte = '0;

    // Reset state
    repeat (2) tick();
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_fault", fault, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    rst_n = 1'b1;

    // Back-to-back load at base 10
    start_load(10, 2);
    check("t2_busy", load_busy, 1);
    check("t2_ready", in_ready, 1);
    send_byte(8'h23); send_byte(8'h01); send_byte(8'h67); send_byte(8'h45);
    check("t2_done", load_done, 1);
    check("t2_ready_off", in_ready, 0);
    check("t2_busy_off", load_busy, 0);
    tick();
    check("t2_done_once", load_done, 0);
    read(10);
    check("t2_rd10", data, 32'h0123);
    check("t2_rd10_valid", valid, 1);
    check("t2_rd10_fault", fault, 0);
    read(11);
    check("t2_rd11", data, 32'h4567);

    // Same stream with idle gaps between bytes, at base 30
    start_load(30, 2);
    send_byte(8'h23);
    repeat (1) begin tick(); check("t3_busy_gap1", load_busy, 1); end
    send_byte(8'h01);
    repeat (2) begin tick(); check("t3_busy_gap2", load_busy, 1); end
    send_byte(8'h67);
    repeat (3) begin tick(); check("t3_busy_gap3", load_busy, 1); end
    send_byte(8'h45);
    check("t3_done", load_done, 1);
    tick();
    read(30);
    check("t3_rd30", data, 32'h0123);
    read(31);
    check("t3_rd31", data, 32'h4567);

    // Out-of-range index and disabled port
    read(1024);
    check("t4_oor_fault", fault, 1);
    check("t4_oor_valid", valid, 0);
    check("t4_oor_data", data, 0);
    read(1034);
    check("t4_notrunc_fault", fault, 1);
    check("t4_notrunc_data", data, 0);
    not_enable = 1'b1;
    read(10);
    check("t4_dis_data", data, 0);
    check("t4_dis_valid", valid, 0);
    check("t4_dis_fault", fault, 0);
    not_enable = 1'b0;

    // Range error on the last word, then a recovering load
    start_load(1023, 1);
    send_byte(8'hCD); send_byte(8'hAB);
    check("t5_done1023", load_done, 1);
    tick();
    read(1023);
    check("t5_rd1023", data, 32'hABCD);
    start_load(1023, 2);
    check("t5_err", load_err, 1);
    check("t5_err_busy", load_busy, 0);
    check("t5_err_done", load_done, 0);
    tick();
    check("t5_err_done2", load_done, 0);
    start_load(32'hFFFF_FFFF, 2);
    check("t5_wrap_err", load_err, 1);
    check("t5_wrap_busy", load_busy, 0);
    read(1023);
    check("t5_rd1023_kept", data, 32'hABCD);
    index = 1023;
    start_load(1022, 2);
    check("t5_preload_read", data, 32'hABCD);
    check("t5_err_clear", load_err, 0);
    check("t5_edge_busy", load_busy, 1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t5_edge_done", load_done, 1);
    tick();
    read(1022);
    check("t5_rd1022", data, 32'h2211);
    read(1023);
    check("t5_rd1023_new", data, 32'h4433);

    // Reset in the middle of a load
    start_load(20, 2);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hBB);
    tick();
    start_load(20, 2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst_n = 1'b0;
    tick();
    check("t6_rst_busy", load_busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_done", load_done, 0);
    rst_n = 1'b1;
    read(20);
    check("t6_rd20", data, 32'h2211);
    read(21);
    check("t6_rd21", data, 32'hBBBB);
    start_load(21, 0);
    check("t6_len0_done", load_done, 1);
    check("t6_len0_busy", load_busy, 0);
    tick();
    check("t6_len0_once", load_done, 0);
    read(21);
    check("t6_rd21_after", data, 32'hBBBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
